// File: rtl/conv_layer_sched_if.sv
// rtl/conv_layer_sched_if.sv - weight-memory, conv-core and output-capture signals of the layer scheduler
interface conv_layer_sched_if #(
  parameter int IC   = 8,
  parameter int OC_W = 4
);
  logic              wt_re;
  logic [OC_W-1:0]   wt_addr;
  logic [IC*9-1:0]   wt_rdata;
  logic              core_run;
  logic [IC*9-1:0]   core_weights;
  logic              core_done;
  logic              out_we;
  logic [OC_W-1:0]   out_oc;

  // Scheduler side
  modport master (
    output wt_re, wt_addr, core_run, core_weights, out_we, out_oc,
    input  wt_rdata, core_done
  );

  // Memory / core / feature-map buffer side
  modport slave (
    input  wt_re, wt_addr, core_run, core_weights, out_we, out_oc,
    output wt_rdata, core_done
  );
endinterface

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - sequences one conv core over all output channels; optional CONV_SCHED_PERF_EN cycle counter
module conv_layer_sched #(
  parameter int IC     = 8,
  parameter int OC_MAX = 16,
  parameter int OC_W   = $clog2(OC_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [OC_W:0]     cfg_num_oc_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       perf_cycles_o,
  conv_layer_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    RUN   = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [OC_W:0] OC_MAX_L = (OC_W+1)'(OC_MAX);
  localparam logic [OC_W:0] ONE_L    = (OC_W+1)'(1);

  state_t            state_q;
  logic [OC_W-1:0]   oc_q;
  logic [OC_W:0]     num_oc_q;
  logic              busy_q;
  logic              done_q;
  logic              wt_re_q;
  logic [OC_W-1:0]   wt_addr_q;
  logic              core_run_q;
  logic [IC*9-1:0]   core_weights_q;
  logic              out_we_q;
  logic [OC_W-1:0]   out_oc_q;

  logic              start_acc;
  logic [OC_W:0]     num_oc_clamped;
  logic              last_oc;

  // A start is only taken in IDLE, and a coincident abort suppresses it
  assign start_acc      = (state_q == IDLE) && start_i && !abort_i;
  assign num_oc_clamped = (cfg_num_oc_i > OC_MAX_L) ? OC_MAX_L : cfg_num_oc_i;
  assign last_oc        = ({1'b0, oc_q} == (num_oc_q - ONE_L));

  // Channel sequencer; every output is set on the transition into the state that owns it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      oc_q           <= '0;
      num_oc_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wt_re_q        <= 1'b0;
      wt_addr_q      <= '0;
      core_run_q     <= 1'b0;
      core_weights_q <= '0;
      out_we_q       <= 1'b0;
      out_oc_q       <= '0;
    end else if (abort_i && (state_q != IDLE)) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wt_re_q    <= 1'b0;
      core_run_q <= 1'b0;
      out_we_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            num_oc_q <= num_oc_clamped;
            oc_q     <= '0;
            busy_q   <= 1'b1;
            if (cfg_num_oc_i == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              wt_re_q   <= 1'b1;
              wt_addr_q <= '0;
              state_q   <= FETCH;
            end
          end
        end
        FETCH: begin
          wt_re_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          core_weights_q <= bus.wt_rdata;
          core_run_q     <= 1'b1;
          state_q        <= RUN;
        end
        RUN: begin
          if (bus.core_done) begin
            core_run_q <= 1'b0;
            out_we_q   <= 1'b1;
            out_oc_q   <= oc_q;
            state_q    <= STORE;
          end
        end
        STORE: begin
          out_we_q <= 1'b0;
          if (last_oc) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            oc_q      <= oc_q + OC_W'(1);
            wt_re_q   <= 1'b1;
            wt_addr_q <= oc_q + OC_W'(1);
            state_q   <= FETCH;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign bus.wt_re        = wt_re_q;
  assign bus.wt_addr      = wt_addr_q;
  assign bus.core_run     = core_run_q;
  assign bus.core_weights = core_weights_q;
  assign bus.out_we       = out_we_q;
  assign bus.out_oc       = out_oc_q;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Core-active cycle count: restarts on each accepted start, saturates, holds when idle
  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (core_run_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Perf counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb/tb_conv_layer_sched.sv - scoreboard bench for conv_layer_sched with weight memory and stub core
module tb_conv_layer_sched;
  localparam int IC     = 8;
  localparam int OC_MAX = 16;
  localparam int OC_W   = 4;
  localparam int WW     = IC*9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [OC_W:0]   cfg = '0;
  logic            busy;
  logic            done;
  logic [31:0]     perf;

  conv_layer_sched_if #(.IC(IC), .OC_W(OC_W)) bus ();

  conv_layer_sched #(.IC(IC), .OC_MAX(OC_MAX), .OC_W(OC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .cfg_num_oc_i  (cfg),
    .busy_o        (busy),
    .done_o        (done),
    .perf_cycles_o (perf),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  // Weight memory with one-cycle read latency
  logic [WW-1:0] mem [OC_MAX];
  logic [WW-1:0] rdata_q = '0;
  always @(posedge clk) if (bus.wt_re) rdata_q <= mem[bus.wt_addr];
  assign bus.wt_rdata = rdata_q;

  // Stub core: completion pulse 20 cycles after core_run rises
  logic stub_done = 1'b0;
  logic spur_done = 1'b0;
  int   stub_cnt  = 0;
  always @(posedge clk) begin
    if (bus.core_run) begin
      stub_cnt  <= stub_cnt + 1;
      stub_done <= (stub_cnt == 19);
    end else begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end
  end
  assign bus.core_done = stub_done | spur_done;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_q[$];
  int out_q[$];
  int done_cnt = 0;
  int stores_seen = 0;
  int low_cnt = 0;
  bit run_prev = 1'b0;
  bit gap_armed = 1'b0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on reads and stores, tracks core_run gaps
  always @(negedge clk) begin
    if (rst) begin
      run_prev  = 1'b0;
      gap_armed = 1'b0;
      low_cnt   = 0;
    end else begin
      if (bus.wt_re) begin
        if (rd_q.size() == 0) chk("wt_re_extra", WW'(1), WW'(0));
        else chk("wt_addr", WW'(bus.wt_addr), WW'(rd_q.pop_front()));
      end
      if (bus.out_we) begin
        if (out_q.size() == 0) chk("out_we_extra", WW'(1), WW'(0));
        else begin
          int e;
          e = out_q.pop_front();
          chk("out_oc", WW'(bus.out_oc), WW'(e));
          chk("core_weights", bus.core_weights, mem[e]);
        end
        stores_seen++;
        gap_armed = 1'b1;
      end
      if (done) done_cnt++;
      if (bus.core_run) begin
        if (!run_prev && gap_armed) chk("run_gap_ge3", WW'(low_cnt >= 3), WW'(1));
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      if (!busy) gap_armed = 1'b0;
      run_prev = bus.core_run;
    end
  end

  task automatic run_layer(input int cfgv, input bit inject);
    int  n;
    int  d0;
    bit  got;
    bit  wre_last;
    n = (cfgv > OC_MAX) ? OC_MAX : cfgv;
    d0 = done_cnt;
    got = 1'b0;
    wre_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(i);
      out_q.push_back(i);
    end
    cfg = (OC_W+1)'(cfgv);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (inject) begin
        start     = (i == 3) || (i == 50);
        spur_done = bus.wt_re | wre_last | bus.out_we;
        wre_last  = bus.wt_re;
      end
      tick();
    end
    start = 1'b0;
    spur_done = 1'b0;
    chk("done_seen", WW'(got), WW'(1));
    tick();
    chk("busy_after_done", WW'(busy), WW'(0));
    chk("done_one_cycle", WW'(done), WW'(0));
    chk("rd_left", WW'(rd_q.size()), WW'(0));
    chk("out_left", WW'(out_q.size()), WW'(0));
    chk("done_count", WW'(done_cnt - d0), WW'(1));
`ifdef CONV_SCHED_PERF_EN
    chk("perf", WW'(perf), WW'(n * 21));
`else
    chk("perf", WW'(perf), WW'(0));
`endif
    rd_q.delete();
    out_q.delete();
  endtask

  initial begin
    int d0;
    int s0;
    bit hit;
    for (int i = 0; i < OC_MAX; i++) mem[i] = WW'({$urandom, $urandom, $urandom});

    // Reset state
    repeat (3) tick();
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_done", WW'(done), WW'(0));
    chk("rst_wt_re", WW'(bus.wt_re), WW'(0));
    chk("rst_core_run", WW'(bus.core_run), WW'(0));
    chk("rst_out_we", WW'(bus.out_we), WW'(0));
    chk("rst_weights", bus.core_weights, WW'(0));
    chk("rst_perf", WW'(perf), WW'(0));
    rst = 1'b0;
    tick();

    // Basic three-channel run
    run_layer(3, 1'b0);

    // Zero channels
    d0 = done_cnt;
    cfg = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", WW'(done), WW'(1));
    chk("zero_busy", WW'(busy), WW'(1));
    chk("zero_core_run", WW'(bus.core_run), WW'(0));
    chk("zero_wt_re", WW'(bus.wt_re), WW'(0));
    chk("zero_perf", WW'(perf), WW'(0));
    tick();
    chk("zero_done_clr", WW'(done), WW'(0));
    chk("zero_idle", WW'(busy), WW'(0));
    chk("zero_done_cnt", WW'(done_cnt - d0), WW'(1));

    // Abort during RUN of channel 1
    d0 = done_cnt;
    s0 = stores_seen;
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(i);
      out_q.push_back(i);
    end
    cfg = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ((stores_seen == s0 + 1) && bus.core_run) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach_run1", WW'(hit), WW'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", WW'(busy), WW'(0));
    chk("abort_core_run", WW'(bus.core_run), WW'(0));
    chk("abort_out_we", WW'(bus.out_we), WW'(0));
    rd_q.delete();
    out_q.delete();
    repeat (40) tick();
    chk("abort_no_done", WW'(done_cnt - d0), WW'(0));
    chk("abort_no_store", WW'(stores_seen - s0), WW'(1));
    run_layer(4, 1'b0);

    // Start pulses while busy and spurious core_done outside RUN
    run_layer(3, 1'b1);

    // Reset asserted in WAIT
    d0 = done_cnt;
    rd_q.push_back(0);
    out_q.push_back(0);
    cfg = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_fetch", WW'(bus.wt_re), WW'(1));
    tick();
    rst = 1'b1;
    tick();
    chk("mid_busy", WW'(busy), WW'(0));
    chk("mid_done", WW'(done), WW'(0));
    chk("mid_wt_re", WW'(bus.wt_re), WW'(0));
    chk("mid_wt_addr", WW'(bus.wt_addr), WW'(0));
    chk("mid_core_run", WW'(bus.core_run), WW'(0));
    chk("mid_weights", bus.core_weights, WW'(0));
    chk("mid_out_we", WW'(bus.out_we), WW'(0));
    chk("mid_out_oc", WW'(bus.out_oc), WW'(0));
    chk("mid_perf", WW'(perf), WW'(0));
    rst = 1'b0;
    rd_q.delete();
    out_q.delete();
    repeat (30) tick();
    chk("mid_no_done", WW'(done_cnt - d0), WW'(0));

    // Clamp to OC_MAX
    s0 = stores_seen;
    run_layer(OC_MAX + 1, 1'b0);
    chk("clamp_stores", WW'(stores_seen - s0), WW'(OC_MAX));

    // Simultaneous start and abort in IDLE
    d0 = done_cnt;
    cfg = 5'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", WW'(busy), WW'(0));
    chk("sa_wt_re", WW'(bus.wt_re), WW'(0));
    repeat (5) tick();
    chk("sa_busy_late", WW'(busy), WW'(0));
    chk("sa_no_done", WW'(done_cnt - d0), WW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Sequences one ConvCore instance over all output channels of a binary conv layer.
- Per output channel: fetch that channel's packed 3x3xIC weight word from weight memory, start the core, wait for its completion pulse, emit a write strobe so the downstream feature-map buffer captures the core's output image, then clear the core.
- Sits between the layer-level controller (start/done) and the conv datapath. Image data is wired straight to the core; this block never touches it.

Parameters:
- IC, 8, input channels; core weight word width is IC*9.
- OC_MAX, 16, maximum output channels per layer run.
- OC_W, $clog2(OC_MAX), width of channel index and weight address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  1-cycle request to run a layer; sampled only in IDLE.
- abort  in  1  cancels the run in progress.
- cfg_num_oc  in  OC_W+1  output channels to run; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when all channels have been stored.
- wt_re  out  1  weight memory read enable.
- wt_addr  out  OC_W  weight memory address, equal to the channel index.
- wt_rdata  in  IC*9  weight word, valid one cycle after wt_re.
- core_run  out  1  drives the core data_in_ready; low means the core is held cleared.
- core_weights  out  IC*9  registered weight word presented to the core.
- core_done  in  1  the core data_out_ready (1-cycle pulse).
- out_we  out  1  capture strobe for the core img_out.
- out_oc  out  OC_W  channel index for out_we.
- perf_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values: all outputs 0, state IDLE, oc=0, latched num_oc=0. Reset mid-run forces IDLE on the next edge; no done pulse.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, RUN, STORE, DONE.
- IDLE:
  - start=1 with cfg_num_oc>0 -> latch num_oc, set oc=0, go to FETCH.
  - start=1 with cfg_num_oc=0 -> go to DONE without running any channel.
  - cfg_num_oc>OC_MAX is clamped to OC_MAX.
- FETCH: wt_re=1, wt_addr=oc for exactly one cycle -> WAIT.
- WAIT: latch wt_rdata into core_weights -> RUN. core_weights holds its value until the next WAIT.
- RUN:
  - core_run=1.
  - On sampled core_done=1 -> STORE; core_run goes 0 from STORE onward.
  - No timeout; the block waits indefinitely.
- STORE:
  - out_we=1 and out_oc=oc for exactly one cycle, while the core img_out is still valid. The core clears at the end of this cycle.
  - If oc==num_oc-1 -> DONE; else increment oc -> FETCH.
- DONE: done=1 for one cycle -> IDLE.
- core_run is low for at least 3 cycles (STORE, FETCH, WAIT) between channels, which guarantees the core is cleared.
- Per-channel overhead outside the core's compute time: 4 cycles (FETCH, WAIT, STORE, plus the RUN detect cycle). Layer overhead adds 1 cycle for DONE.
- start while busy: ignored.
- abort in any non-IDLE state: IDLE on the next edge, core_run=0, no out_we, no done.
- abort and start in the same IDLE cycle: abort wins; the block stays IDLE.
- core_done outside RUN: ignored.

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- Defined:
  - perf_cycles counts cycles with core_run=1.
  - Cleared to 0 on accepted start; saturates at 32'hFFFFFFFF.
  - Holds its value after done or abort until the next start.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Basic run: stub core with core_done 20 cycles after core_run rises; rst, then start with cfg_num_oc=3. Required: 3 FETCH reads at wt_addr 0,1,2; out_we with out_oc=0,1,2; each core_weights equal to the memory word for its channel; one done pulse; busy low after done. With PERF_EN: perf_cycles=63 (3 x 21).
- Zero channels: start with cfg_num_oc=0 -> done pulses 1 cycle after start; no wt_re, no core_run, no out_we.
- Abort during RUN of channel 1 (cfg_num_oc=4) -> IDLE next cycle, core_run=0, no further out_we, no done. A following start runs all 4 channels from oc=0.
- Reset mid-run: rst asserted in WAIT -> all outputs 0 on the next cycle. Ignored inputs: start pulses while busy and spurious core_done in FETCH/WAIT/STORE cause no extra channels or strobes.
- Clamp and gap: cfg_num_oc=OC_MAX+1 (17) -> exactly 16 out_we. Every gap between channels has core_run=0 for at least 3 consecutive cycles.
- Simultaneous start+abort in IDLE -> busy stays 0 and no wt_re is issued.
